// File: rtl/seg7_pkg.sv
// Shared definitions for the BCD seven-segment scanner: nibble width and
// active-high segment patterns in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b0111111;
  localparam seg7_t SEG_1     = 7'b0000110;
  localparam seg7_t SEG_2     = 7'b1011011;
  localparam seg7_t SEG_3     = 7'b1001111;
  localparam seg7_t SEG_4     = 7'b1100110;
  localparam seg7_t SEG_5     = 7'b1101101;
  localparam seg7_t SEG_6     = 7'b1111101;
  localparam seg7_t SEG_7     = 7'b0000111;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1101111;
  localparam seg7_t SEG_DASH  = 7'b1000000;
  localparam seg7_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high {g..a}.
// Non-decimal codes render as a dash; blank_i forces all segments off.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             blank_i,
  output seg7_t            seg_o
);

  // Pattern lookup, overridden by blanking
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed common-anode seven-segment scanner. One digit per slot of
// SCAN_DIV cycles, the first GUARD cycles of each slot with all anodes off.
// All digits are snapshotted at frame start so carries never tear a frame.
module bcd_7seg_scan
  import seg7_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int SCAN_DIV   = 12000,
  parameter int GUARD      = 16,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [BCD_W*NDIGITS-1:0]   digits,
  input  logic [NDIGITS-1:0]         dp_in,
  output logic [SEG_W-1:0]           seg,
  output logic                       dp,
  output logic [NDIGITS-1:0]         an,
  output logic                       frame
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NDIGITS);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NDIGITS - 1);

  // Inactive output levels; XOR with these applies the output polarity
  localparam logic               POL     = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]   SEG_OFF = {SEG_W{POL}};
  localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{POL}};

  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BCD_W*NDIGITS-1:0] snap_q;
  logic [NDIGITS-1:0]       snapdp_q;
  logic [SEG_W-1:0]         seg_q;
  logic                     dp_q;
  logic [NDIGITS-1:0]       an_q;
  logic                     frame_q;

  logic                     slot_end;
  logic                     frame_wrap;
  logic [BCD_W-1:0]         cur_bcd;
  logic                     cur_dp;
  logic                     cur_blank;
  logic                     zero_run;
  logic [NDIGITS-1:0]       an_sel;
  seg7_t                    seg_raw;

  // Prescaler and digit index advance; the last slot of a frame is the wrap
  always_comb begin
    slot_end   = (presc_q == PRESC_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    presc_d    = slot_end ? '0 : presc_q + PRESC_W'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the current snapshot digit and work out leading-zero blanking:
  // scanning from the top digit down, zero_run stays set while every digit
  // at or above position i is zero.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    an_sel    = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (snap_q[BCD_W*i +: BCD_W] == '0);
      if (idx_q == IDX_W'(i)) begin
        cur_bcd   = snap_q[BCD_W*i +: BCD_W];
        cur_dp    = snapdp_q[i];
        cur_blank = (BLANK_LZ != 0) && (i != 0) && zero_run;
        an_sel[i] = 1'b1;
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd_i   (cur_bcd),
    .blank_i (cur_blank),
    .seg_o   (seg_raw)
  );

  // Scan state and frame snapshot; disabled scanning parks at slot 0 and
  // tracks the inputs so the first slot after enable shows fresh digits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      snapdp_q <= '0;
    end else if (!enable) begin
      presc_q  <= '0;
      idx_q    <= '0;
      snap_q   <= digits;
      snapdp_q <= dp_in;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (frame_wrap) begin
        snap_q   <= digits;
        snapdp_q <= dp_in;
      end
    end
  end

  // Registered display drive; anodes stay off during the guard interval
  // while segments already carry the new digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q   <= SEG_OFF;
      dp_q    <= POL;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else if (!enable) begin
      seg_q   <= SEG_OFF;
      dp_q    <= POL;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_raw ^ SEG_OFF;
      dp_q    <= cur_dp ^ POL;
      an_q    <= (presc_q < GUARD_END) ? AN_OFF : (an_sel ^ AN_OFF);
      frame_q <= frame_wrap;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: two instances (with and without leading-zero
// blanking) compared every cycle against a frame/slot arithmetic model,
// plus directed spot checks of known display states.
module tb_bcd_7seg_scan;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        frame_a, frame_b;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.NDIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .reset(rst_n), .enable(en), .digits(digits), .dp_in(dp_in),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a)
  );

  bcd_7seg_scan #(.NDIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(0), .ACTIVE_LOW(1)) u_dut_nb (
    .clk(clk), .reset(rst_n), .enable(en), .digits(digits), .dp_in(dp_in),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: cycles since scanning (re)started and the frame snapshot
  int          cyc;
  logic [15:0] msnap;
  logic [3:0]  mdp;
  logic [6:0]  e_seg_a, e_seg_b;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_frame;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
    end
  endtask

  // Active-high {g..a} glyphs
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic model_reset();
    cyc     = 0;
    msnap   = '0;
    mdp     = '0;
    e_seg_a = 7'h7F;
    e_seg_b = 7'h7F;
    e_dp    = 1'b1;
    e_an    = 4'hF;
    e_frame = 1'b0;
  endtask

  // Expected outputs after one clock edge, from the state before it
  task automatic model_edge();
    int         ph;
    int         sl;
    logic [3:0] nib;
    logic       blank;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en) begin
      cyc     = 0;
      msnap   = digits;
      mdp     = dp_in;
      e_seg_a = 7'h7F;
      e_seg_b = 7'h7F;
      e_dp    = 1'b1;
      e_an    = 4'hF;
      e_frame = 1'b0;
      return;
    end
    ph      = cyc % SD;
    sl      = (cyc / SD) % ND;
    nib     = 4'(msnap >> (4 * sl));
    blank   = (sl > 0) && ((msnap >> (4 * sl)) == 16'h0);
    e_seg_b = ~glyph(nib);
    e_seg_a = blank ? 7'h7F : ~glyph(nib);
    e_dp    = ~mdp[sl];
    e_an    = (ph < GD) ? 4'hF : ~(4'b0001 << sl);
    e_frame = ((cyc % (ND * SD)) == ND * SD - 1);
    if (e_frame) begin
      msnap = digits;
      mdp   = dp_in;
    end
    cyc++;
  endtask

  task automatic compare();
    check_eq("seg_lz",   32'(seg_a),   32'(e_seg_a));
    check_eq("seg_nolz", 32'(seg_b),   32'(e_seg_b));
    check_eq("dp",       32'(dp_a),    32'(e_dp));
    check_eq("dp_nolz",  32'(dp_b),    32'(e_dp));
    check_eq("an",       32'(an_a),    32'(e_an));
    check_eq("an_nolz",  32'(an_b),    32'(e_an));
    check_eq("frame",    32'(frame_a), 32'(e_frame));
    check_eq("frame_nolz", 32'(frame_b), 32'(e_frame));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Park with enable low so the next enabled slot 0 shows these inputs
  task automatic load_idle(input logic [15:0] d, input logic [3:0] p);
    en     = 1'b0;
    digits = d;
    dp_in  = p;
    step();
    step();
    en = 1'b1;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    int          q;
    logic [3:0]  nib;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      q = $urandom_range(0, 99);
      if (q < 40)      nib = 4'd0;
      else if (q < 85) nib = 4'($urandom_range(1, 9));
      else             nib = 4'($urandom_range(10, 15));
      r = r | (16'(nib) << (4 * i));
    end
    return r;
  endfunction

  initial begin
    model_reset();
    rst_n  = 1'b1;
    en     = 1'b0;
    digits = 16'h1234;
    dp_in  = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    compare();
    check_eq("rst_an", 32'(an_a), 32'h0000_000F);
    check_eq("rst_seg", 32'(seg_a), 32'h0000_007F);
    repeat (3) step();
    rst_n = 1'b1;

    // First frame of 1234
    load_idle(16'h1234, 4'h0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1)  check_eq("s1_guard_an", 32'(an_a), 32'h0000_000F);
      if (k == 1)  check_eq("s1_guard_seg", 32'(seg_a), 32'h0000_0019);
      if (k == 3)  check_eq("s1_an", 32'(an_a), 32'h0000_000E);
      if (k == 3)  check_eq("s1_seg", 32'(seg_a), 32'h0000_0019);
      if (k == 11) check_eq("s2_an", 32'(an_a), 32'h0000_000D);
      if (k == 11) check_eq("s2_seg", 32'(seg_a), 32'h0000_0030);
      if (k == 19) check_eq("s3_an", 32'(an_a), 32'h0000_000B);
      if (k == 19) check_eq("s3_seg", 32'(seg_a), 32'h0000_0024);
      if (k == 27) check_eq("s4_an", 32'(an_a), 32'h0000_0007);
      if (k == 27) check_eq("s4_seg", 32'(seg_a), 32'h0000_0079);
      if (k == 31) check_eq("frame_pre", 32'(frame_a), 32'h0);
      if (k == 32) check_eq("frame_pulse", 32'(frame_a), 32'h1);
    end

    // Leading-zero blanking of 0050
    load_idle(16'h0050, 4'h0);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 3)  check_eq("lz_d0", 32'(seg_a), 32'h0000_0040);
      if (k == 11) check_eq("lz_d1", 32'(seg_a), 32'h0000_0012);
      if (k == 19) check_eq("lz_d2", 32'(seg_a), 32'h0000_007F);
      if (k == 27) check_eq("lz_d3", 32'(seg_a), 32'h0000_007F);
      if (k == 27) check_eq("nolz_d3", 32'(seg_b), 32'h0000_0040);
    end

    // Mid-frame change 0009 -> 0010 stays hidden until the next frame
    load_idle(16'h0009, 4'h0);
    for (int k = 1; k <= 48; k++) begin
      if (k == 20) digits = 16'h0010;
      step();
      if (k == 3)  check_eq("tear_f1_d0", 32'(seg_a), 32'h0000_0010);
      if (k == 27) check_eq("tear_f1_d3", 32'(seg_a), 32'h0000_007F);
      if (k == 35) check_eq("tear_f2_d0", 32'(seg_a), 32'h0000_0040);
      if (k == 43) check_eq("tear_f2_d1", 32'(seg_a), 32'h0000_0079);
    end

    // Invalid nibble renders a dash with its decimal point
    load_idle(16'h000C, 4'b0001);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 3)  check_eq("dash_seg", 32'(seg_a), 32'h0000_003F);
      if (k == 3)  check_eq("dash_dp", 32'(dp_a), 32'h0);
      if (k == 11) check_eq("dash_d1_dp", 32'(dp_a), 32'h1);
    end

    // Reset in the middle of slot 3
    load_idle(16'h1234, 4'h0);
    repeat (28) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    check_eq("midrst_an", 32'(an_a), 32'h0000_000F);
    check_eq("midrst_seg", 32'(seg_a), 32'h0000_007F);
    check_eq("midrst_frame", 32'(frame_a), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) check_eq("rst_restart_guard", 32'(an_a), 32'h0000_000F);
      if (k == 3) check_eq("rst_restart_an", 32'(an_a), 32'h0000_000E);
    end
    repeat (20) step();

    // Disable for 20 cycles, then re-enable
    en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_eq("dis_an", 32'(an_a), 32'h0000_000F);
      check_eq("dis_frame", 32'(frame_a), 32'h0);
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) check_eq("reen_guard", 32'(an_a), 32'h0000_000F);
      if (k == 3) check_eq("reen_an", 32'(an_a), 32'h0000_000E);
      if (k == 3) check_eq("reen_seg", 32'(seg_a), 32'h0000_0019);
    end

    // Randomized run with input churn, enable drops and async resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 6) digits = rand_digits();
      if ($urandom_range(0, 99) < 6) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) en = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 999) < 4) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
